// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state codes,
// wait-counter width, word size and the access error rule.
package dmem_pkg;

    localparam int CNT_W      = 4;
    localparam int WORD_BYTES = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic                      we;
        logic [31:0]               addr;
        logic [31:0]               wdata;
        logic [WORD_BYTES-1:0]     be;
    } req_t;

    // Misaligned, or any address bit above the word index is set.
    function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a data-memory initiator and the responder.
// Handshake: a beat transfers on a rising edge where valid and ready are both 1;
// the initiator holds req_* stable until it sees req_ready, and the responder
// holds rsp_* stable while rsp_valid=1 and rsp_ready=0.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables: synchronous write,
// combinational read on the same word address. Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [WORD_BYTES-1:0] i_be,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, performs the access and holds the response until taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  io_bus,
    output logic [1:0]       o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_cnt
);

    localparam logic [CNT_W-1:0] LP_CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    req_t              r_req;
    logic              r_rsp_valid;
    logic [31:0]       r_rdata;
    logic              r_err;

    req_t              w_cur;
    logic              w_accept;
    logic              w_access;
    logic              w_err;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_word;
    logic [31:0]       w_mem_rdata;

    assign w_accept = (r_state == ST_IDLE) && io_bus.req_valid;

    // With zero wait states the access edge is the acceptance edge, so the
    // live request has to be used because nothing is latched yet.
    always_comb begin
        w_cur = r_req;
        if (r_state == ST_IDLE) begin
            w_cur = '{we:    io_bus.req_we,
                      addr:  io_bus.req_addr,
                      wdata: io_bus.req_wdata,
                      be:    io_bus.req_be};
        end
    end

    assign w_access = (w_accept && (WAIT_CYCLES == 0)) ||
                      ((r_state == ST_WAIT) && (r_cnt == '0));
    assign w_err    = addr_err(w_cur.addr, ADDR_W);
    assign w_word   = w_cur.addr[ADDR_W+1:2];
    assign w_wr_en  = w_access && w_cur.we && !w_err;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_addr  (w_word),
        .i_be    (w_cur.be),
        .i_wdata (w_cur.wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req       <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.req_valid) begin
                        r_req <= w_cur;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LP_CNT_INIT;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (io_bus.rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_access) begin
                r_rsp_valid <= 1'b1;
                r_err       <= w_err;
                r_rdata     <= (w_cur.we || w_err) ? 32'd0 : w_mem_rdata;
            end else if ((r_state == ST_RESP) && io_bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign io_bus.req_ready = reset && (r_state == ST_IDLE);
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_rdata = r_rdata;
    assign io_bus.rsp_err   = r_err;
    assign o_dbg_state      = r_state;
    assign o_dbg_cnt        = r_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none,
// checked against directed vectors and a byte-level memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int ADDR_W = 6;
    localparam int WORDS  = 2**ADDR_W;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_responder_if if_a();
    dmem_responder_if if_b();

    logic [1:0]       dbg_state_a, dbg_state_b;
    logic [CNT_W-1:0] dbg_cnt_a, dbg_cnt_b;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(rst_n), .io_bus(if_a),
        .o_dbg_state(dbg_state_a), .o_dbg_cnt(dbg_cnt_a)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(rst_n), .io_bus(if_b),
        .o_dbg_state(dbg_state_b), .o_dbg_cnt(dbg_cnt_b)
    );

    logic        rdy  [2];
    logic        rvld [2];
    logic        rerr [2];
    logic [31:0] rdat [2];
    int          exp_lat [2] = '{3, 1};

    assign rdy[0]  = if_a.req_ready;
    assign rdy[1]  = if_b.req_ready;
    assign rvld[0] = if_a.rsp_valid;
    assign rvld[1] = if_b.rsp_valid;
    assign rerr[0] = if_a.rsp_err;
    assign rerr[1] = if_b.rsp_err;
    assign rdat[0] = if_a.rsp_rdata;
    assign rdat[1] = if_b.rsp_rdata;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_m [2][WORDS];
    logic [32:0] exp_q [$];
    int          last_accept [2];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        if (sel == 0) begin
            if_a.req_valid = v; if_a.req_we = we; if_a.req_addr = a;
            if_a.req_wdata = wd; if_a.req_be = be;
        end else begin
            if_b.req_valid = v; if_b.req_we = we; if_b.req_addr = a;
            if_b.req_wdata = wd; if_b.req_be = be;
        end
    endtask

    // Reference: returns {err, rdata} and applies stores to the byte model.
    function automatic logic [32:0] model(input int sel, input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] be);
        int widx;
        if ((addr % 4) != 0 || addr >= 32'(WORDS * 4)) return {1'b1, 32'd0};
        widx = int'(addr / 4);
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_m[sel][widx][8*i +: 8] = wdata[8*i +: 8];
            return {1'b0, 32'd0};
        end
        return {1'b0, mem_m[sel][widx]};
    endfunction

    task automatic run_txn(input int sel, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [31:0] rd, output logic e, output int lat);
        int n;
        @(negedge clk);
        drive(sel, 1'b1, we, addr, wdata, be);
        n = 0;
        while (!rdy[sel] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL accept_timeout dut=%0d got no req_ready expected req_ready=1", sel);
        end
        @(posedge clk);
        #1;
        last_accept[sel] = cyc;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        lat = 1;
        while (!rvld[sel] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) begin
            total++; bad++;
            $display("FAIL rsp_timeout dut=%0d got no rsp_valid expected rsp_valid=1", sel);
        end
        rd = rdat[sel];
        e  = rerr[sel];
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {63'd0, if_a.req_ready}, 64'd0);
        check({tag, "_rsp_valid"}, {63'd0, if_a.rsp_valid}, 64'd0);
        check({tag, "_rdata"},     {32'd0, if_a.rsp_rdata}, 64'd0);
        check({tag, "_err"},       {63'd0, if_a.rsp_err},   64'd0);
        check({tag, "_state"},     {62'd0, dbg_state_a},    {62'd0, ST_IDLE});
        check({tag, "_cnt"},       {60'd0, dbg_cnt_a},      64'd0);
        check({tag, "_b_ready"},   {63'd0, if_b.req_ready}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic [32:0] exp;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  be;
        int          sel;

        tbl.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        tbl.push_back('{1'b0, 32'h22,       32'h0,        4'h0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h00,       32'h12345678, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h100,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h00,       32'h0,        4'h0, 32'h12345678, 1'b0});
        tbl.push_back('{1'b1, 32'h24,       32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h24,       32'h00000000, 4'h0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h24,       32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b1, 32'hFC,       32'hA5A5A5A5, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'hFC,       32'h0,        4'h0, 32'hA5A5A5A5, 1'b0});
        tbl.push_back('{1'b0, 32'h80000000, 32'h0,        4'h0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h28,       32'h11111111, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h28,       32'h22334455, 4'hA, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h28,       32'h0,        4'h0, 32'h22114411, 1'b0});
        tbl.push_back('{1'b1, 32'h30,       32'h00000005, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h30,       32'h0,        4'h0, 32'h00000005, 1'b0});

        // Clock/reset
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        if_a.rsp_ready = 1'b1;
        if_b.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_ready_a", {63'd0, if_a.req_ready}, 64'd1);
        check("post_reset_ready_b", {63'd0, if_b.req_ready}, 64'd1);

        // Give both arrays known contents
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < WORDS; w++) begin
                wd = $urandom;
                void'(model(s, 1'b1, 32'(w * 4), wd, 4'hF));
                run_txn(s, 1'b1, 32'(w * 4), wd, 4'hF, rd, e, lat);
            end
        end

        // Directed vectors on the two-wait-state instance
        foreach (tbl[i]) begin
            void'(model(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be));
            run_txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, e, lat);
            check($sformatf("vec%0d_rdata", i), {32'd0, rd}, {32'd0, tbl[i].exp_rd});
            check($sformatf("vec%0d_err", i),   {63'd0, e},  {63'd0, tbl[i].exp_err});
            check($sformatf("vec%0d_lat", i),   64'(lat),    64'd3);
        end

        // Back-pressure: response held for 5 cycles, new request ignored
        @(negedge clk);
        if_a.rsp_ready = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        lat = 0;
        while (!if_a.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_rsp_valid_seen", {63'd0, if_a.rsp_valid}, 64'd1);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_valid", k), {63'd0, if_a.rsp_valid}, 64'd1);
            check($sformatf("bp%0d_rdata", k), {32'd0, if_a.rsp_rdata}, {32'd0, 32'hDEADBEEF});
            check($sformatf("bp%0d_err", k),   {63'd0, if_a.rsp_err},   64'd0);
            check($sformatf("bp%0d_ready", k), {63'd0, if_a.req_ready}, 64'd0);
        end
        @(negedge clk);
        if_a.rsp_ready = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        check("bp_ready_before_hs", {63'd0, if_a.req_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("bp_ready_after_hs", {63'd0, if_a.req_ready}, 64'd1);
        check("bp_valid_after_hs", {63'd0, if_a.rsp_valid}, 64'd0);
        run_txn(0, 1'b0, 32'h10, 32'd0, 4'd0, rd, e, lat);
        check("bp_ignored_store", {32'd0, rd}, {32'd0, 32'hDEADBEEF});

        // Reset during WAIT of a store to 0x30 (holds 0x5)
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("mid_state_wait", {62'd0, dbg_state_a}, {62'd0, ST_WAIT});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", {63'd0, if_a.req_ready}, 64'd1);
        check("mid_rel_valid", {63'd0, if_a.rsp_valid}, 64'd0);
        check("mid_rel_rdata", {32'd0, if_a.rsp_rdata}, 64'd0);
        check("mid_rel_err",   {63'd0, if_a.rsp_err},   64'd0);
        run_txn(0, 1'b0, 32'h30, 32'd0, 4'd0, rd, e, lat);
        check("mid_load_0x30", {32'd0, rd}, 64'd5);
        check("mid_load_lat",  64'(lat), 64'd3);

        // Zero wait states: back-to-back loads, one accept every 2 cycles
        for (int i = 0; i < 4; i++) begin
            int prev;
            prev = last_accept[1];
            addr = 32'($urandom_range(0, WORDS - 1) * 4);
            exp  = model(1, 1'b0, addr, 32'd0, 4'd0);
            run_txn(1, 1'b0, addr, 32'd0, 4'd0, rd, e, lat);
            check($sformatf("zw%0d_rdata", i), {31'd0, e, rd}, {31'd0, exp});
            check($sformatf("zw%0d_lat", i), 64'(lat), 64'd1);
            if (i > 0) check($sformatf("zw%0d_gap", i), 64'(last_accept[1] - prev), 64'd2);
        end

        // Randomized traffic against the model on both instances
        for (int i = 0; i < 160; i++) begin
            sel = i % 2;
            case ($urandom_range(0, 9))
                0:       addr = 32'($urandom_range(0, WORDS * 4 - 1)) | 32'd1;
                1:       addr = ($urandom | 32'h100) & ~32'h3;
                default: addr = 32'($urandom_range(0, WORDS - 1) * 4);
            endcase
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            be  = 4'($urandom_range(0, 15));
            exp_q.push_back(model(sel, we, addr, wd, be));
            run_txn(sel, we, addr, wd, be, rd, e, lat);
            exp = exp_q.pop_front();
            check($sformatf("rnd%0d_rsp a=%h we=%0d", i, addr, we), {31'd0, e, rd}, {31'd0, exp});
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat[sel]));
        end

        // Read back every word of both arrays
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < WORDS; w++) begin
                exp = model(s, 1'b0, 32'(w * 4), 32'd0, 4'd0);
                run_txn(s, 1'b0, 32'(w * 4), 32'd0, 4'd0, rd, e, lat);
                check($sformatf("final_d%0d_w%0d", s, w), {31'd0, e, rd}, {31'd0, exp});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
